// File: rtl/lockpick_key_sequencer_pkg.sv
// Shared types and constants for the lockpick key sequencer and its result checker.
// beat_match() decides whether one result-burst byte is the byte expected for a status.
package lockpick_pkg;

  localparam int KEY_BYTES = 32;
  localparam int MSG_BYTES = 16;

  localparam logic [15:0] MSG_WIN    = 16'hFACE;
  localparam logic [15:0] MSG_LOCKED = 16'hDEAD;
  localparam logic [15:0] MSG_ERROR  = 16'hBAD0;

  typedef enum logic [1:0] {
    ST_NONE   = 2'b00,
    ST_ERROR  = 2'b01,
    ST_WIN    = 2'b10,
    ST_LOCKED = 2'b11
  } status_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    STREAM,
    WAIT_RES,
    DRAIN,
    REPORT
  } seq_state_t;

  // Even beats carry the low byte of the status word and odd beats carry the high byte.
  // ST_NONE has no word, so no byte can match it.
  function automatic logic beat_match(input status_t st, input logic odd, input logic [7:0] data);
    logic [15:0] word;
    logic        known;
    known = 1'b1;
    case (st)
      ST_WIN:    word = MSG_WIN;
      ST_LOCKED: word = MSG_LOCKED;
      ST_ERROR:  word = MSG_ERROR;
      default: begin
        word  = 16'h0000;
        known = 1'b0;
      end
    endcase
    return known && (data == (odd ? word[15:8] : word[7:0]));
  endfunction

endpackage

// File: rtl/lockpick_key_sequencer_if.sv
// Host byte stream, game-core link and result summary of the key sequencer, grouped as one bundle.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface lockpick_key_sequencer_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       clear;
  logic       go;

  logic       game_start;
  logic       game_input_enable;
  logic [7:0] game_input_data;
  logic       game_output_valid;
  logic [7:0] game_output_data;
  logic [1:0] game_status;

  logic       busy;
  logic       done;
  logic [1:0] result_code;
  logic       msg_ok;

  modport slave (
    input  in_valid, in_data, clear, go,
    input  game_output_valid, game_output_data, game_status,
    output in_ready, game_start, game_input_enable, game_input_data,
    output busy, done, result_code, msg_ok
  );

  modport master (
    output in_valid, in_data, clear, go,
    output game_output_valid, game_output_data, game_status,
    input  in_ready, game_start, game_input_enable, game_input_data,
    input  busy, done, result_code, msg_ok
  );

endinterface

// File: rtl/lockpick_key_sequencer_result_checker.sv
// Follows the game's result burst: it counts beats, captures the status at beat 0 and
// accumulates a byte-by-byte pattern match.
module lockpick_result_checker
  import lockpick_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       first_i,
  input  logic       active_i,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  input  status_t    status_i,
  output logic       burst_done_o,
  output logic       burst_short_o,
  output logic       msg_ok_o,
  output status_t    status_o
);

  localparam int BEAT_W = $clog2(MSG_BYTES);

  logic [BEAT_W-1:0] beat_q, beat_d, cur_beat;
  status_t           status_q, status_d, cur_status;
  logic              ok_q, ok_d;
  logic              beat_ok, fire;

  // Beat 0 arrives while the sequencer is still waiting, so it is compared against the live status.
  always_comb begin
    cur_status = first_i ? status_i : status_q;
    cur_beat   = first_i ? '0 : beat_q;
    beat_ok    = beat_match(cur_status, cur_beat[0], data_i);
    fire       = first_i | (active_i & valid_i);

    beat_d   = beat_q;
    status_d = status_q;
    ok_d     = ok_q;
    if (fire) begin
      beat_d   = cur_beat + 1'b1;
      status_d = cur_status;
      ok_d     = (first_i | ok_q) & beat_ok;
    end

    burst_done_o  = active_i & valid_i & (beat_q == BEAT_W'(MSG_BYTES - 1));
    burst_short_o = active_i & ~valid_i;
    msg_ok_o      = burst_done_o & ok_q & beat_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q   <= '0;
      status_q <= ST_NONE;
      ok_q     <= 1'b0;
    end else begin
      beat_q   <= beat_d;
      status_q <= status_d;
      ok_q     <= ok_d;
    end
  end

  assign status_o = status_q;

endmodule

// File: rtl/lockpick_key_sequencer.sv
// Buffers one 32-byte key attempt from the host, replays it into the lockpick game core,
// then checks the game's result burst and reports a one-cycle summary.
module lockpick_key_sequencer
  import lockpick_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
)(
  input logic                    clk,
  input logic                    rst_n,
  lockpick_key_sequencer_if.slave bus
);

  localparam int FILL_W = $clog2(KEY_BYTES + 1);
  localparam int IDX_W  = $clog2(KEY_BYTES);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_t        state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              armed_q, armed_d;

  logic              start_q, start_d;
  logic              en_q, en_d;
  logic [7:0]        data_q, data_d;
  logic              done_q, done_d;
  status_t           code_q, code_d;
  logic              ok_q, ok_d;

  logic [7:0]        key_buf [KEY_BYTES];
  logic              in_ready, buf_full, wr_en;
  logic              chk_first, chk_active, chk_done, chk_short, chk_msg_ok;
  status_t           chk_status;

  assign buf_full = (fill_q == FILL_W'(KEY_BYTES));
  assign in_ready = (state_q == IDLE) && (fill_q < FILL_W'(KEY_BYTES));
  assign wr_en    = bus.in_valid && in_ready && !bus.clear;

  assign chk_first  = (state_q == WAIT_RES) && bus.game_output_valid;
  assign chk_active = (state_q == DRAIN);

  lockpick_result_checker u_checker (
    .clk           (clk),
    .rst_n         (rst_n),
    .first_i       (chk_first),
    .active_i      (chk_active),
    .valid_i       (bus.game_output_valid),
    .data_i        (bus.game_output_data),
    .status_i      (status_t'(bus.game_status)),
    .burst_done_o  (chk_done),
    .burst_short_o (chk_short),
    .msg_ok_o      (chk_msg_ok),
    .status_o      (chk_status)
  );

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    idx_d   = '0;
    tmo_d   = tmo_q;
    armed_d = armed_q;
    code_d  = code_q;
    ok_d    = ok_q;

    case (state_q)
      IDLE: begin
        if (bus.clear) begin
          fill_d = '0;
        end else begin
          if (wr_en) fill_d = fill_q + 1'b1;
          // An armed game is already waiting for key A, so no new start pulse.
          if (bus.go && buf_full) state_d = armed_q ? STREAM : START;
        end
      end
      START: state_d = STREAM;
      STREAM: begin
        idx_d = idx_q + 1'b1;
        tmo_d = TMO_W'(1);
        if (idx_q == IDX_W'(KEY_BYTES - 1)) state_d = WAIT_RES;
      end
      WAIT_RES: begin
        // tmo_q holds the number of cycles since the last key byte.
        tmo_d = tmo_q + 1'b1;
        if (bus.game_output_valid) begin
          state_d = DRAIN;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = REPORT;
          code_d  = ST_NONE;
          ok_d    = 1'b0;
          armed_d = 1'b0;
        end
      end
      DRAIN: begin
        if (chk_done || chk_short) begin
          state_d = REPORT;
          code_d  = chk_status;
          ok_d    = chk_msg_ok;
          armed_d = (chk_status == ST_ERROR);
        end
      end
      REPORT: begin
        fill_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so each flop lines up with its state cycle.
    start_d = (state_d == START);
    en_d    = (state_d == STREAM);
    data_d  = en_d ? key_buf[idx_d] : 8'h00;
    done_d  = (state_d == REPORT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fill_q  <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      armed_q <= 1'b0;
      start_q <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      code_q  <= ST_NONE;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      armed_q <= armed_d;
      start_q <= start_d;
      en_q    <= en_d;
      data_q  <= data_d;
      done_q  <= done_d;
      code_q  <= code_d;
      ok_q    <= ok_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) key_buf[fill_q[IDX_W-1:0]] <= bus.in_data;
  end

  assign bus.in_ready          = in_ready;
  assign bus.busy              = (state_q != IDLE);
  assign bus.game_start        = start_q;
  assign bus.game_input_enable = en_q;
  assign bus.game_input_data   = data_q;
  assign bus.done              = done_q;
  assign bus.result_code       = code_q;
  assign bus.msg_ok            = ok_q;

endmodule

// File: tb/tb_lockpick_key_sequencer.sv
// Bench for lockpick_key_sequencer: a behavioural game stub answers each attempt, and
// scoreboard queues hold the expected stream bytes and the expected result summaries.
module tb_lockpick_key_sequencer;
  import lockpick_pkg::*;

  localparam int M_GAME = 0, M_WIN = 1, M_SILENT = 2, M_CORRUPT = 3, M_SHORT = 4;

  typedef struct packed {
    logic [1:0] code;
    logic       ok;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lockpick_key_sequencer_if bus();

  lockpick_key_sequencer #(.TIMEOUT_CYCLES(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] sb_stream[$];
  res_t       sb_res[$];

  int         mode = M_GAME;
  int         n_starts = 0, en_cnt = 0, rx_cnt = 0, g_att = 0;
  int         first_en_cyc = 0, last_en_cyc = 0, last_beat_cyc = 0;
  int         done_cyc = 0, done_cnt = 0;
  int         lat = 0, tx_beat = 0;
  bit         tx_pend = 1'b0;
  bit         exp_armed = 1'b0;
  logic [1:0] tx_status = 2'b00;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [7:0] burst_byte(input logic [1:0] st, input int beat);
    logic [15:0] w;
    case (st)
      2'b10:   w = 16'hFACE;
      2'b11:   w = 16'hDEAD;
      2'b01:   w = 16'hBAD0;
      default: w = 16'h0000;
    endcase
    return beat[0] ? w[15:8] : w[7:0];
  endfunction

  // Game stub: locks out on the third attempt after a start in M_GAME mode.
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_cnt = 0;
      g_att = 0;
      tx_pend = 1'b0;
      bus.game_output_valid = 1'b0;
      bus.game_output_data = 8'h00;
      bus.game_status = 2'b00;
    end else begin
      bus.game_output_valid = 1'b0;
      bus.game_output_data = 8'h00;
      if (bus.game_start) begin
        n_starts++;
        rx_cnt = 0;
        g_att = 0;
      end
      if (bus.game_input_enable) begin
        if (en_cnt == 0) first_en_cyc = cyc;
        last_en_cyc = cyc;
        en_cnt++;
        check_eq("stream_q_avail", sb_stream.size() > 0, 1);
        if (sb_stream.size() > 0) check_eq("stream_byte", bus.game_input_data, sb_stream.pop_front());
        rx_cnt++;
        if (rx_cnt == KEY_BYTES) begin
          rx_cnt = 0;
          g_att++;
          tx_status = (mode == M_GAME) ? ((g_att >= 3) ? 2'b11 : 2'b01) : 2'b10;
          tx_pend = (mode != M_SILENT);
          tx_beat = 0;
          lat = 4;
        end
      end else if (tx_pend) begin
        if (lat > 0) begin
          lat--;
        end else begin
          bus.game_output_valid = 1'b1;
          bus.game_status = tx_status;
          bus.game_output_data = burst_byte(tx_status, tx_beat);
          if (mode == M_CORRUPT && tx_beat == 7) bus.game_output_data = 8'hCE;
          last_beat_cyc = cyc;
          tx_beat++;
          if (tx_beat == ((mode == M_SHORT) ? 10 : MSG_BYTES)) tx_pend = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    res_t r;
    if (rst_n && bus.done) begin
      check_eq("res_q_avail", sb_res.size() > 0, 1);
      if (sb_res.size() > 0) begin
        r = sb_res.pop_front();
        check_eq("result_code", bus.result_code, r.code);
        check_eq("msg_ok", bus.msg_ok, r.ok);
      end
      done_cyc = cyc;
      done_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_key(input int base, input int step, input int nbytes, output int accepted);
    accepted = 0;
    for (int i = 0; i < nbytes; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'(base + i * step);
      if (bus.in_ready) begin
        sb_stream.push_back(bus.in_data);
        accepted++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int budget);
    int i;
    i = 0;
    while (done_cnt == n0 && i < budget) begin
      tick();
      i++;
    end
    check_eq("done_seen", done_cnt != n0, 1);
  endtask

  task automatic run_attempt(input int m, input logic [1:0] exp_code, input logic exp_ok,
                             input int base, input int step);
    int   acc, s0, n0, go_cyc;
    res_t r;
    mode = m;
    push_key(base, step, KEY_BYTES, acc);
    check_eq("accepted", acc, KEY_BYTES);
    s0 = n_starts;
    n0 = done_cnt;
    en_cnt = 0;
    r.code = exp_code;
    r.ok = exp_ok;
    sb_res.push_back(r);
    bus.go = 1'b1;
    go_cyc = cyc;
    tick();
    bus.go = 1'b0;
    wait_done(n0, 400);
    check_eq("start_pulses", n_starts - s0, exp_armed ? 0 : 1);
    check_eq("enable_cycles", en_cnt, KEY_BYTES);
    check_eq("enable_contig", last_en_cyc - first_en_cyc, KEY_BYTES - 1);
    check_eq("first_byte_lat", first_en_cyc - go_cyc, exp_armed ? 1 : 2);
    tick();
    check_eq("idle_busy", bus.busy, 0);
    check_eq("idle_ready", bus.in_ready, 1);
    check_eq("code_held", bus.result_code, exp_code);
    exp_armed = (exp_code == 2'b01);
  endtask

  initial begin
    int acc, i;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.clear = 1'b0;
    bus.go = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check_eq("rst_in_ready", bus.in_ready, 1);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_outs", {bus.game_start, bus.game_input_enable, bus.game_input_data,
                          bus.done, bus.result_code, bus.msg_ok}, 0);
    rst_n = 1'b1;
    tick();

    // Retry sequence until lockout, then a fresh start.
    run_attempt(M_GAME, 2'b01, 1'b1, 0, 0);
    run_attempt(M_GAME, 2'b01, 1'b1, 0, 0);
    run_attempt(M_GAME, 2'b11, 1'b1, 8'h11, 3);
    run_attempt(M_GAME, 2'b01, 1'b1, 8'h20, 5);
    run_attempt(M_WIN, 2'b10, 1'b1, 8'h33, 1);
    check_eq("full_done_lat", done_cyc - last_beat_cyc, 1);

    run_attempt(M_SILENT, 2'b00, 1'b0, 8'h5A, 9);
    check_eq("timeout_lat", done_cyc - last_en_cyc, 64);
    run_attempt(M_CORRUPT, 2'b10, 1'b0, 8'h77, 2);
    run_attempt(M_SHORT, 2'b10, 1'b0, 8'h81, 4);
    check_eq("short_done_lat", done_cyc - last_beat_cyc, 2);

    // Backpressure and clear.
    push_key(8'h40, 1, 40, acc);
    check_eq("bp_accepted", acc, KEY_BYTES);
    check_eq("bp_ready_low", bus.in_ready, 0);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    sb_stream.delete();
    check_eq("clear_ready", bus.in_ready, 1);
    push_key(8'h90, 1, 40, acc);
    check_eq("bp_after_clear", acc, KEY_BYTES);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    sb_stream.delete();

    run_attempt(M_GAME, 2'b01, 1'b1, 8'hA0, 7);

    // Reset in the middle of the key stream.
    mode = M_WIN;
    push_key(8'hC0, 1, KEY_BYTES, acc);
    en_cnt = 0;
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    i = 0;
    while (en_cnt < 12 && i < 100) begin
      tick();
      i++;
    end
    check_eq("rst_reach_byte12", en_cnt, 12);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_start", bus.game_start, 0);
    check_eq("midrst_enable", bus.game_input_enable, 0);
    check_eq("midrst_data", bus.game_input_data, 0);
    check_eq("midrst_result", {bus.done, bus.result_code, bus.msg_ok}, 0);
    check_eq("midrst_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    sb_stream.delete();
    exp_armed = 1'b0;
    tick();
    check_eq("post_rst_ready", bus.in_ready, 1);
    run_attempt(M_GAME, 2'b01, 1'b1, 8'h05, 11);
    check_eq("res_q_empty", sb_res.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lockpick_key_sequencer.md
Name: lockpick_key_sequencer

Overview:
Host-side feeder placed directly upstream of the lockpick game core. It buffers one 32-byte attempt (key A then key B) from a valid/ready byte stream and, on request, replays it into the game's start/input_enable/input_data interface. It then drains the game's 16-byte result burst, checks that burst against the pattern expected for the reported status, and returns a one-cycle result summary. It also tracks whether the game is waiting for a retry key without a new start.

Parameters:
KEY_BYTES, 32, bytes per attempt: key A is bytes 0-15, key B is bytes 16-31; fixed by the game core.
MSG_BYTES, 16, length of the result burst from the game.
TIMEOUT_CYCLES, 64, maximum cycles from the last key byte to the first output_valid.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  host byte valid
in_data  in  8  host byte
in_ready  out  1  buffer accepts a byte
clear  in  1  empty the buffer; honoured in IDLE only
go  in  1  request an attempt; honoured in IDLE only, with a full buffer
game_start  out  1  to game start
game_input_enable  out  1  to game input_enable
game_input_data  out  8  to game input_data
game_output_valid  in  1  from game output_valid
game_output_data  in  8  from game output_data
game_status  in  2  from game status
busy  out  1  high in every state except IDLE
done  out  1  one-cycle result pulse
result_code  out  2  captured status; 00 means timeout
msg_ok  out  1  burst matched the expected pattern

Behaviour:
- Reset: state IDLE, fill_count=0, armed=0. All outputs are 0 except in_ready=1.
- All game-side outputs and all result outputs are registered.
- IDLE:
  - in_ready = (fill_count<32).
  - A byte is written to buf[fill_count] when in_valid && in_ready; fill_count then increments.
  - clear sets fill_count=0; clear wins over a simultaneous write.
  - go with fill_count==32: if armed=0, go to START; if armed=1, go to STREAM directly (the game is already waiting in its key-A phase).
  - go with fill_count<32 is ignored.
- START: game_start=1 for exactly one cycle, then STREAM. No gap cycle: byte 0 is driven in the cycle immediately after the start-high cycle.
- STREAM: 32 consecutive cycles with game_input_enable=1 and game_input_data=buf[i], i=0..31, in order. Then WAIT_RES with game_input_enable=0 and game_input_data=0.
- WAIT_RES:
  - The timeout counter counts cycles.
  - game_output_valid=1 moves to DRAIN; that cycle's byte counts as beat 0.
  - Counter reaching TIMEOUT_CYCLES moves to REPORT with result_code=00, msg_ok=0, armed=0.
- DRAIN:
  - Capture game_status at beat 0.
  - Expected byte per beat: even beat = low byte, odd beat = high byte of the status word. Status words: 10 -> FACE (CE, FA), 11 -> DEAD (AD, DE), 01 -> BAD0 (D0, BA). Status 00 matches nothing.
  - Any byte mismatch clears the msg_ok accumulator.
  - Leave DRAIN after 16 valid beats.
  - If game_output_valid drops before beat 16: msg_ok=0, leave immediately.
- REPORT:
  - done=1 for one cycle, with result_code and msg_ok valid in the same cycle; both hold until the next REPORT.
  - armed = (captured status==01).
  - fill_count=0, so the buffer is consumed.
  - Return to IDLE.
- Host writes outside IDLE are refused (in_ready=0). go and clear are ignored outside IDLE.
- Reset asserted mid-operation returns everything to reset values immediately. The game core shares rst_n, so armed=0 stays consistent with it.

Decomposition:
- Package lockpick_pkg holds:
  - status_t enum: ST_NONE=00, ST_ERROR=01, ST_WIN=10, ST_LOCKED=11.
  - Message word constants: MSG_WIN=16'hFACE, MSG_LOCKED=16'hDEAD, MSG_ERROR=16'hBAD0.
  - KEY_BYTES, MSG_BYTES.
  - The sequencer state enum: IDLE, START, STREAM, WAIT_RES, DRAIN, REPORT.
- One sub-module, lockpick_result_checker, owns the DRAIN beat counter, status capture, and pattern compare. It outputs burst_done, burst_short and msg_ok.

Test Plan:
- Push 32 zero bytes, then go, against a real game core -> one game_start pulse, then 32 enable cycles; result done with result_code=01, msg_ok=1, burst D0,BA repeated; armed=1.
- Second attempt with the same data -> no game_start pulse; stream begins the cycle after go is sampled.
- Attempts continued until the game locks out -> result_code=11, burst AD,DE repeated, msg_ok=1, armed=0; the next go emits game_start.
- Backpressure: push 40 bytes with in_valid held high -> exactly 32 accepted, in_ready=0 after the 32nd. clear restores in_ready=1 and fill_count=0.
- Game stub that never raises output_valid -> done exactly TIMEOUT_CYCLES (64) cycles after the last key byte, with result_code=00 and msg_ok=0.
- Stub that sends status 10 with one corrupted byte at beat 7 (CE instead of FA) -> msg_ok=0.
- Stub that sends only 10 beats -> done right after beat 9, msg_ok=0.
- rst_n pulsed during STREAM at byte 12 -> all outputs 0 asynchronously, in_ready=1 after release, fill_count=0.
